// File: rtl/cpu8_pkg.sv
// Shared types and constants for the 8-bit CPU pipeline.
// Used by the MEM->WB stage and its writeback buffer.
package cpu8_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int WB_DEPTH   = 2;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic                  regwrite;
    } wb_entry_t;

    // r0 is hardwired to zero, so a write aimed at it is never a real write
    function automatic logic real_write(input logic regwrite, input logic [REG_ADDR_W-1:0] rd);
        return regwrite && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle of MEM-side capture, register-file writeback, forwarding and
// status signals for the MEM->WB stage.
interface mem_wb_stage_if #(
    parameter int CNT_W = 16
);
    import cpu8_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     ALUresult_mem_address;
    logic [DATA_W-1:0]     mem_data;
    logic                  MemtoReg;
    logic                  RegWrite;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0]     wb_data;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_reg;
    logic [DATA_W-1:0]     fwd_data;
    logic [CNT_W-1:0]      retired_count;

    modport master (
        output in_valid, ALUresult_mem_address, mem_data, MemtoReg, RegWrite,
               write_reg, flush, out_ready,
        input  in_ready, out_valid, wb_en, wb_reg, wb_data,
               fwd_valid, fwd_reg, fwd_data, retired_count
    );

    modport slave (
        input  in_valid, ALUresult_mem_address, mem_data, MemtoReg, RegWrite,
               write_reg, flush, out_ready,
        output in_ready, out_valid, wb_en, wb_reg, wb_data,
               fwd_valid, fwd_reg, fwd_data, retired_count
    );

endinterface

// File: rtl/wb_skid_buffer.sv
// Two-deep FIFO of writeback entries with flush; exposes the oldest (head)
// and newest (youngest) entries, both zero when empty.
module wb_skid_buffer
    import cpu8_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_flush,
    input  wb_entry_t i_entry,
    output logic [1:0] o_count,
    output wb_entry_t o_head,
    output wb_entry_t o_youngest
);

    wb_entry_t  r_mem [WB_DEPTH];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = i_push && (r_count < 2'(WB_DEPTH));
    assign w_do_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

    // Storage needs no reset: every read is qualified by r_count
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
    end

    always_comb begin
        o_head     = '0;
        o_youngest = '0;
        if (r_count != 2'd0) begin
            o_head     = r_mem[r_rd_ptr];
            o_youngest = r_mem[~r_wr_ptr];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: selects the writeback value at capture, buffers up
// to two instructions, drives the register-file port, forwarding tap and retire count.
module mem_wb_stage
    import cpu8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    wb_entry_t        w_entry;
    wb_entry_t        w_head;
    wb_entry_t        w_youngest;
    logic [1:0]       w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_out_valid;
    logic             w_in_ready;
    logic [CNT_W-1:0] r_retired_count;

    always_comb begin
        w_entry          = '0;
        w_entry.data     = bus.MemtoReg ? bus.mem_data : bus.ALUresult_mem_address;
        w_entry.reg_addr = bus.write_reg;
        w_entry.regwrite = real_write(bus.RegWrite, bus.write_reg);
    end

    // Full means refuse input even when the head is draining this cycle
    assign w_in_ready  = (w_count < 2'(WB_DEPTH));
    assign w_out_valid = (w_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    wb_skid_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (bus.flush),
        .i_entry    (w_entry),
        .o_count    (w_count),
        .o_head     (w_head),
        .o_youngest (w_youngest)
    );

    // A pop on a flush cycle still retires
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_count <= '0;
        end else if (w_pop) begin
            r_retired_count <= r_retired_count + CNT_W'(1);
        end
    end

    always_comb begin
        bus.in_ready      = w_in_ready;
        bus.out_valid     = w_out_valid;
        bus.wb_en         = w_pop && w_head.regwrite;
        bus.wb_reg        = w_head.reg_addr;
        bus.wb_data       = w_head.data;
        bus.fwd_valid     = w_youngest.regwrite;
        bus.fwd_reg       = w_youngest.reg_addr;
        bus.fwd_data      = w_youngest.data;
        bus.retired_count = r_retired_count;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a queue-based
// reference model of the MEM->WB stage.
module tb_mem_wb_stage;
    import cpu8_pkg::*;

    logic clk;
    logic rst;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t m_q[$];
    int        m_retired = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        wb_entry_t hd;
        wb_entry_t yg;
        logic      ov;
        hd = '0;
        yg = '0;
        ov = (m_q.size() > 0);
        if (ov) begin
            hd = m_q[0];
            yg = m_q[m_q.size()-1];
        end
        check_eq("in_ready",  32'(bus.in_ready),  32'(m_q.size() < 2));
        check_eq("out_valid", 32'(bus.out_valid), 32'(ov));
        check_eq("wb_en",     32'(bus.wb_en),     32'(ov && bus.out_ready && hd.regwrite));
        check_eq("wb_reg",    32'(bus.wb_reg),    32'(hd.reg_addr));
        check_eq("wb_data",   32'(bus.wb_data),   32'(hd.data));
        check_eq("fwd_valid", 32'(bus.fwd_valid), 32'(yg.regwrite));
        check_eq("fwd_reg",   32'(bus.fwd_reg),   32'(yg.reg_addr));
        check_eq("fwd_data",  32'(bus.fwd_data),  32'(yg.data));
        check_eq("retired",   32'(bus.retired_count), 32'(m_retired % 65536));
    endtask

    task automatic model_step(input bit rs, input bit iv, input bit mtr, input bit rw,
                              input logic [2:0] wr, input logic [7:0] alu, input logic [7:0] md,
                              input bit fl, input bit ordy);
        wb_entry_t e;
        bit        do_pop;
        bit        do_push;
        if (rs) begin
            m_q.delete();
            m_retired = 0;
        end else begin
            do_pop  = (m_q.size() > 0) && ordy;
            do_push = iv && (m_q.size() < 2);
            if (do_pop) m_retired++;
            if (fl) begin
                m_q.delete();
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) begin
                    e.data     = mtr ? md : alu;
                    e.reg_addr = wr;
                    e.regwrite = rw && (wr != 3'd0);
                    m_q.push_back(e);
                end
            end
        end
    endtask

    // Drive on the falling edge, check just after, advance the model for the next rising edge
    task automatic cycle(input bit rs, input bit iv, input bit mtr, input bit rw,
                         input logic [2:0] wr, input logic [7:0] alu, input logic [7:0] md,
                         input bit fl, input bit ordy, input bit chk);
        @(negedge clk);
        rst                       = rs;
        bus.in_valid              = iv;
        bus.MemtoReg              = mtr;
        bus.RegWrite              = rw;
        bus.write_reg             = wr;
        bus.ALUresult_mem_address = alu;
        bus.mem_data              = md;
        bus.flush                 = fl;
        bus.out_ready             = ordy;
        #1;
        if (chk) check_model();
        model_step(rs, iv, mtr, rw, wr, alu, md, fl, ordy);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, ordy, 1'b1);
    endtask

    initial begin
        int guard;
        rst                       = 1'b1;
        bus.in_valid              = 1'b0;
        bus.MemtoReg              = 1'b0;
        bus.RegWrite              = 1'b0;
        bus.write_reg             = '0;
        bus.ALUresult_mem_address = '0;
        bus.mem_data              = '0;
        bus.flush                 = 1'b0;
        bus.out_ready             = 1'b0;

        // reset for two cycles, then idle state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset_retired",  32'(bus.retired_count), 32'd0);

        // load writes memory data
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h2A, 8'h54, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        check_eq("load_wb_en",   32'(bus.wb_en),   32'd1);
        check_eq("load_wb_reg",  32'(bus.wb_reg),  32'd3);
        check_eq("load_wb_data", 32'(bus.wb_data), 32'h54);
        idle(1'b0);
        check_eq("load_retired", 32'(bus.retired_count), 32'd1);

        // two ALU writes to r1 while blocked: full, newest forwarded, drain in order
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h10, 8'hEE, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'h20, 8'hEE, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'h77, 8'hEE, 1'b0, 1'b0, 1'b1);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("full_fwd_data", 32'(bus.fwd_data), 32'h20);
        idle(1'b1);
        check_eq("drain0_wb_data", 32'(bus.wb_data), 32'h10);
        idle(1'b1);
        check_eq("drain1_wb_data", 32'(bus.wb_data), 32'h20);
        idle(1'b1);

        // write to r0 is not a register write but still retires
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check_eq("r0_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("r0_wb_en",     32'(bus.wb_en),     32'd0);
        check_eq("r0_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        idle(1'b0);

        // flush on a full buffer drops the same-cycle capture, then reset mid-stream
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h31, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'h32, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_wb_en",     32'(bus.wb_en),     32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 8'h41, 8'h42, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h43, 8'h44, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        check_eq("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_mid_fwd_data",  32'(bus.fwd_data),  32'd0);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 4) < 3, 1'b1);
        end

        // retired-count wrap: stream pops until 16'hFFFF, then one more
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (m_retired < 65535 && guard < 70000) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 8'(guard), 8'h00, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        check_eq("wrap_reached", 32'(m_retired), 32'd65535);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        check_eq("wrap_pre",  32'(bus.retired_count), 32'hFFFF);
        idle(1'b1);
        check_eq("wrap_zero", 32'(bus.retired_count), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
